// File: rtl/mdio_master.sv
// MDIO (Clause 22) management master.
// Serialises one register read or write at a time onto Mdc/Mdo/MdoEn/Mdi
// and returns a one-cycle completion pulse plus the last read data.
// Optional build macro: MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble,
// shortening every frame to 32 bits.
module mdio_master #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        busy,
  input  logic        Mdi,
  output logic        Mdo,
  output logic        MdoEn,
  output logic        Mdc
);

  // Divider: counts clk_sys cycles within one Mdc half-period.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Field lengths inside a frame.
  localparam int HDR_BITS  = 14;  // ST + OP + PHYAD + REGAD
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int FRAME_BITS = 32;
`else
  localparam int PRE_BITS   = 32;
  localparam int FRAME_BITS = 64;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    mdc_q, mdc_d;
  logic                    mdoen_q, mdoen_d;
  logic                    write_q, write_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [15:0]             rd_shift_q, rd_shift_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    resp_valid_q, resp_valid_d;

  logic [FRAME_BITS-1:0]   frame_load;
  logic [HDR_BITS-1:0]     hdr_bits;
  logic [TA_BITS-1:0]      ta_bits;
  logic [DATA_BITS-1:0]    data_bits;
  logic                    accept;
  logic                    div_wrap;
  logic                    bit_end;

  // Build the outgoing frame from the request fields; read TA/DATA are
  // don't-care on the wire (MdoEn is low there), so they are loaded as zero.
  always_comb begin
    hdr_bits  = {2'b01, (req_write ? 2'b01 : 2'b10), req_phy_addr, req_reg_addr};
    ta_bits   = req_write ? 2'b10 : 2'b00;
    data_bits = req_write ? req_wdata : 16'h0000;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    frame_load = {hdr_bits, ta_bits, data_bits};
`else
    frame_load = {{PRE_BITS{1'b1}}, hdr_bits, ta_bits, data_bits};
`endif
  end

  assign accept   = req_valid && (state_q == S_IDLE);
  assign div_wrap = (div_q == DIV_LAST);
  // A bit ends on the edge where Mdc falls: end of the high phase.
  assign bit_end  = div_wrap && mdc_q;

  // Next-state, divider, shifter and completion logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    mdc_d        = mdc_q;
    mdoen_d      = mdoen_q;
    write_d      = write_q;
    frame_d      = frame_q;
    rd_shift_d   = rd_shift_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;

    if (state_q == S_IDLE) begin
      // Divider and Mdc are parked while idle.
      div_d = '0;
      mdc_d = 1'b0;
      if (accept) begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        state_d = S_HDR;
`else
        state_d = S_PRE;
`endif
        bit_cnt_d = '0;
        frame_d   = frame_load;
        mdoen_d   = 1'b1;
        write_d   = req_write;
      end
    end else begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) begin
        mdc_d = ~mdc_q;
      end
      if (bit_end) begin
        // Next bit appears on Mdo at the start of its low phase.
        frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        case (state_q)
`ifndef MDIO_PREAMBLE_SUPPRESS_EN
          S_PRE: begin
            if (bit_cnt_q == 5'(PRE_BITS - 1)) begin
              state_d   = S_HDR;
              bit_cnt_d = '0;
            end
          end
`endif
          S_HDR: begin
            if (bit_cnt_q == 5'(HDR_BITS - 1)) begin
              state_d   = S_TA;
              bit_cnt_d = '0;
              // Reads release the line from the first TA bit onward.
              mdoen_d   = write_q;
            end
          end
          S_TA: begin
            if (bit_cnt_q == 5'(TA_BITS - 1)) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end
          end
          S_DATA: begin
            if (!write_q) begin
              rd_shift_d = {rd_shift_q[14:0], Mdi};
            end
            if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
              state_d      = S_IDLE;
              bit_cnt_d    = '0;
              mdoen_d      = 1'b0;
              resp_valid_d = 1'b1;
              if (!write_q) begin
                rdata_d = {rd_shift_q[14:0], Mdi};
              end
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      mdc_q        <= 1'b0;
      mdoen_q      <= 1'b0;
      write_q      <= 1'b0;
      frame_q      <= '0;
      rd_shift_q   <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      mdc_q        <= mdc_d;
      mdoen_q      <= mdoen_d;
      write_q      <= write_d;
      frame_q      <= frame_d;
      rd_shift_q   <= rd_shift_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = !req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign Mdo        = frame_q[FRAME_BITS-1];
  assign MdoEn      = mdoen_q;
  assign Mdc        = mdc_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: table vectors, random transactions
// and hand-written corner sequences, checked against a bit-level frame model.
module tb_mdio_master;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int DIV = 2;
  localparam int N   = 32;
`else
  localparam int DIV = 4;
  localparam int N   = 64;
`endif
  localparam int FRAME_CYC = 2 * DIV * N + 1;

  logic        clk_sys = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy_addr = 5'd0;
  logic [4:0]  req_reg_addr = 5'd0;
  logic [15:0] req_wdata = 16'h0;
  logic        Mdi = 1'b1;
  logic        req_ready, busy, resp_valid, Mdo, MdoEn, Mdc;
  logic [15:0] resp_rdata;

  mdio_master #(.CLK_DIV(DIV)) dut (
    .clk_sys      (clk_sys),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_phy_addr (req_phy_addr),
    .req_reg_addr (req_reg_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .busy         (busy),
    .Mdi          (Mdi),
    .Mdo          (Mdo),
    .MdoEn        (MdoEn),
    .Mdc          (Mdc)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor + PHY model, observed on the falling clk edge.
  logic        prev_mdc = 1'b0;
  int          frame_bit = 0;
  int          acc_cnt = 0;
  logic        cap_mdo[$];
  logic        cap_en[$];
  int          acc_q[$];
  int          resp_q[$];
  logic [15:0] rd_q[$];
  logic        resp_ok_q[$];
  logic [15:0] phy_rd [0:255];

  always @(negedge clk_sys) begin
    if (Mdc && !prev_mdc) begin
      cap_mdo.push_back(Mdo);
      cap_en.push_back(MdoEn);
      // PHY drives DATA bits after the Mdc rise, MSB first.
      if (frame_bit >= N - 16 && acc_cnt > 0)
        Mdi <= phy_rd[(acc_cnt - 1) % 256][N - 1 - frame_bit];
      else
        Mdi <= 1'($urandom);
      frame_bit <= frame_bit + 1;
    end
    prev_mdc <= Mdc;
    if (resp_valid) begin
      resp_q.push_back(cyc);
      rd_q.push_back(resp_rdata);
      resp_ok_q.push_back(!Mdc && !MdoEn && req_ready);
    end
    if (req_valid && req_ready) begin
      acc_q.push_back(cyc);
      acc_cnt   <= acc_cnt + 1;
      frame_bit <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference frame built field by field from the Clause 22 layout.
  logic exp_mdo[$];
  logic exp_en[$];

  task automatic model_frame(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd);
    exp_mdo.delete();
    exp_en.delete();
    if (N == 64) repeat (32) exp_mdo.push_back(1'b1);
    exp_mdo.push_back(1'b0);
    exp_mdo.push_back(1'b1);
    exp_mdo.push_back(!w);
    exp_mdo.push_back(w);
    for (int i = 4; i >= 0; i--) exp_mdo.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) exp_mdo.push_back(rg[i]);
    if (w) begin
      exp_mdo.push_back(1'b1);
      exp_mdo.push_back(1'b0);
      for (int i = 15; i >= 0; i--) exp_mdo.push_back(wd[i]);
    end else begin
      repeat (18) exp_mdo.push_back(1'b0);
    end
    for (int i = 0; i < N; i++) exp_en.push_back(w || (i < N - 18));
  endtask

  // Mismatched bits of one captured frame against the model (Mdo only where driven).
  function automatic int frame_errs(input int base);
    int e = 0;
    for (int i = 0; i < N; i++) begin
      if (base + i >= cap_mdo.size()) e++;
      else if (cap_en[base + i] !== exp_en[i]) e++;
      else if (exp_en[i] && (cap_mdo[base + i] !== exp_mdo[i])) e++;
    end
    return e;
  endfunction

  task automatic wait_acc(input int target, output logic to);
    to = 1'b1;
    for (int t = 0; t < 3 * FRAME_CYC; t++) begin
      if (acc_q.size() >= target) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_resp(input int target, output logic to);
    to = 1'b1;
    for (int t = 0; t < 3 * FRAME_CYC; t++) begin
      if (resp_q.size() >= target) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  logic [15:0] last_rd = 16'h0;
  int          txn_no = 0;

  task automatic drive_req(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd);
    req_write    = w;
    req_phy_addr = phy;
    req_reg_addr = rg;
    req_wdata    = wd;
  endtask

  task automatic scramble_req();
    drive_req(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  task automatic run_txn(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input logic [15:0] rd, output logic [15:0] got);
    int   ab = acc_q.size();
    int   rb = resp_q.size();
    int   cb = cap_mdo.size();
    logic to;
    got = 16'hxxxx;
    phy_rd[ab % 256] = rd;
    tick();
    drive_req(w, phy, rg, wd);
    req_valid = 1'b1;
    wait_acc(ab + 1, to);
    check("accept_timeout", 32'(to), 32'd0);
    req_valid = 1'b0;
    if (to) return;
    scramble_req();
    wait_resp(rb + 1, to);
    check("resp_timeout", 32'(to), 32'd0);
    if (to) return;
    model_frame(w, phy, rg, wd);
    if (!w) last_rd = rd;
    got = rd_q[rb];
    check("latency", 32'(resp_q[rb] - acc_q[ab]), 32'(FRAME_CYC));
    check("bit_count", 32'(cap_mdo.size() - cb), 32'(N));
    check("frame_bits", 32'(frame_errs(cb)), 32'd0);
    check("idle_at_resp", 32'(resp_ok_q[rb]), 32'd1);
    check("resp_rdata", 32'(rd_q[rb]), 32'(last_rd));
    txn_no++;
    $display("txn %0d: %s phy=%0d reg=%0d wdata=0x%04h rdata=0x%04h latency=%0d",
             txn_no, w ? "WR" : "RD", phy, rg, wd, rd_q[rb], resp_q[rb] - acc_q[ab]);
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] got;
    logic        to;
    int          ab, rb, cb, ready_seen;

    vecs[0] = '{w: 1'b1, phy: 5'd1,  rg: 5'd0,  wd: 16'h1200, rd: 16'h0000, exp_rdata: 16'h0000};
    vecs[1] = '{w: 1'b0, phy: 5'd1,  rg: 5'd2,  wd: 16'h0000, rd: 16'hBEEF, exp_rdata: 16'hBEEF};
    vecs[2] = '{w: 1'b1, phy: 5'd31, rg: 5'd31, wd: 16'hFFFF, rd: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[3] = '{w: 1'b0, phy: 5'd0,  rg: 5'd0,  wd: 16'h0000, rd: 16'h0001, exp_rdata: 16'h0001};
    vecs[4] = '{w: 1'b0, phy: 5'd21, rg: 5'd10, wd: 16'h0000, rd: 16'h8001, exp_rdata: 16'h8001};

    // Reset values.
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mdc", 32'(Mdc), 32'd0);
    check("rst_mdo", 32'(Mdo), 32'd0);
    check("rst_mdoen", 32'(MdoEn), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Table vectors.
    foreach (vecs[i]) begin
      run_txn(vecs[i].w, vecs[i].phy, vecs[i].rg, vecs[i].wd, vecs[i].rd, got);
      check("table_rdata", 32'(got), 32'(vecs[i].exp_rdata));
    end

    // Random transactions.
    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), got);
    end

    // Back-to-back: req_valid held, fields changed mid-frame.
    ab = acc_q.size(); rb = resp_q.size(); cb = cap_mdo.size();
    phy_rd[ab % 256]       = 16'h0000;
    phy_rd[(ab + 1) % 256] = 16'hA5C3;
    tick();
    drive_req(1'b1, 5'd5, 5'd9, 16'h3C5A);
    req_valid = 1'b1;
    wait_acc(ab + 1, to);
    check("b2b_accept0", 32'(to), 32'd0);
    drive_req(1'b0, 5'd3, 5'd4, 16'hFFFF);
    wait_acc(ab + 2, to);
    check("b2b_accept1", 32'(to), 32'd0);
    req_valid = 1'b0;
    scramble_req();
    wait_resp(rb + 2, to);
    check("b2b_resp", 32'(to), 32'd0);
    if (!to) begin
      check("b2b_accept_at_resp", 32'(acc_q[ab + 1]), 32'(resp_q[rb]));
      check("b2b_latency1", 32'(resp_q[rb + 1] - acc_q[ab + 1]), 32'(FRAME_CYC));
      model_frame(1'b1, 5'd5, 5'd9, 16'h3C5A);
      check("b2b_frame0", 32'(frame_errs(cb)), 32'd0);
      model_frame(1'b0, 5'd3, 5'd4, 16'h0000);
      check("b2b_frame1", 32'(frame_errs(cb + N)), 32'd0);
      check("b2b_rdata0", 32'(rd_q[rb]), 32'(last_rd));
      last_rd = 16'hA5C3;
      check("b2b_rdata1", 32'(rd_q[rb + 1]), 32'(last_rd));
      $display("txn b2b: WR phy=5 reg=9 then RD phy=3 reg=4 rdata=0x%04h gap=%0d",
               rd_q[rb + 1], acc_q[ab + 1] - resp_q[rb]);
    end

    // Held-off request: asserted mid-frame, must wait for completion.
    ab = acc_q.size(); rb = resp_q.size(); cb = cap_mdo.size();
    phy_rd[ab % 256] = 16'h1357;
    tick();
    drive_req(1'b0, 5'd7, 5'd1, 16'h0000);
    req_valid = 1'b1;
    wait_acc(ab + 1, to);
    check("hold_accept0", 32'(to), 32'd0);
    req_valid = 1'b0;
    repeat (40) tick();
    phy_rd[(ab + 1) % 256] = 16'h0000;
    drive_req(1'b1, 5'd2, 5'd3, 16'hFEDC);
    req_valid = 1'b1;
    ready_seen = 0;
    to = 1'b1;
    for (int t = 0; t < 3 * FRAME_CYC; t++) begin
      if (acc_q.size() >= ab + 2) begin
        to = 1'b0;
        break;
      end
      if (req_ready) ready_seen++;
      tick();
    end
    req_valid = 1'b0;
    check("hold_accept1", 32'(to), 32'd0);
    check("hold_ready_cycles", 32'(ready_seen), 32'd1);
    wait_resp(rb + 2, to);
    check("hold_resp", 32'(to), 32'd0);
    repeat (100) tick();
    check("hold_resp_count", 32'(resp_q.size() - rb), 32'd2);
    check("hold_frame_bits", 32'(cap_mdo.size() - cb), 32'(2 * N));
    if (!to) begin
      last_rd = 16'h1357;
      check("hold_rdata", 32'(rd_q[rb]), 32'(last_rd));
      check("hold_accept_at_resp", 32'(acc_q[ab + 1]), 32'(resp_q[rb]));
      model_frame(1'b1, 5'd2, 5'd3, 16'hFEDC);
      check("hold_frame1", 32'(frame_errs(cb + N)), 32'd0);
      $display("txn hold: RD phy=7 reg=1 rdata=0x%04h then WR phy=2 reg=3", rd_q[rb]);
    end

    // Reset in the middle of a read frame.
    ab = acc_q.size(); cb = cap_mdo.size();
    phy_rd[ab % 256] = 16'h4321;
    tick();
    drive_req(1'b0, 5'd1, 5'd2, 16'h0000);
    req_valid = 1'b1;
    wait_acc(ab + 1, to);
    req_valid = 1'b0;
    check("rstmid_accept", 32'(to), 32'd0);
    to = 1'b1;
    for (int t = 0; t < 3 * FRAME_CYC; t++) begin
      if (cap_mdo.size() >= cb + 20) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check("rstmid_reach_bit20", 32'(to), 32'd0);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rb = resp_q.size();
    rstn = 1'b0;
    #1;
    check("rstmid_mdc", 32'(Mdc), 32'd0);
    check("rstmid_mdoen", 32'(MdoEn), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_rdata", 32'(resp_rdata), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (FRAME_CYC) tick();
    check("rstmid_no_resp", 32'(resp_q.size() - rb), 32'd0);
    $display("txn rst: read abandoned after %0d bits", cap_mdo.size() - cb);
    last_rd = 16'h0000;
    run_txn(1'b0, 5'd1, 5'd2, 16'h0000, 16'h0F0F, got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
